// File: rtl/dme_pulse_pair_sched.sv
// DME interrogator pulse-pair sequencer: emits the ena window for each pulse of a pair,
// with programmable pulse length, pair spacing and an LFSR-jittered repetition interval.
module dme_pulse_pair_sched #(
  parameter int          CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] pair_gap,
  input  logic [CNT_W-1:0] prr_base,
  input  logic [15:0]      jitter_mask,
  output logic             ena,
  output logic             pulse_idx,
  output logic             pair_start,
  output logic             busy,
  output logic             cfg_err,
  output logic [15:0]      pair_count
);

  typedef enum logic [2:0] {IDLE, P1, GAP, P2, WAIT} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] t;
  logic [CNT_W-1:0] len_q, gap_q, prr_q, interval_q, interval_nxt;
  logic [CNT_W-1:0] sel_prr;
  logic [15:0]      mask_q, sel_mask, lfsr, lfsr_step;
  logic [CNT_W:0]   cfg_sum, jit_sum;
  logic             stop_pending, cfg_ok, accept, new_pair;
  logic             ena_nxt, idx_nxt, err_nxt;

  // Sums are formed one bit wider so oversized settings cannot wrap into a "valid" config.
  assign cfg_sum = {1'b0, pair_gap} + {1'b0, pulse_len};
  assign cfg_ok  = (pulse_len != '0) && (pair_gap > pulse_len) && ({1'b0, prr_base} > cfg_sum);
  assign accept  = (state == IDLE) && start && cfg_ok;

  assign sel_prr      = (state == IDLE) ? prr_base : prr_q;
  assign sel_mask     = (state == IDLE) ? jitter_mask : mask_q;
  assign jit_sum      = {1'b0, sel_prr} + {{(CNT_W-15){1'b0}}, lfsr & sel_mask};
  assign interval_nxt = jit_sum[CNT_W] ? '1 : jit_sum[CNT_W-1:0];

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never maps to zero.
  assign lfsr_step = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)                      state_nxt = P1;
      P1:   if (t == len_q - ONE)            state_nxt = GAP;
      GAP:  if (t == gap_q - ONE)            state_nxt = P2;
      P2:   if (t == gap_q + len_q - ONE)    state_nxt = WAIT;
      WAIT: if (t == interval_q - ONE)       state_nxt = (stop_pending || stop) ? IDLE : P1;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    new_pair = (state_nxt == P1) && (state != P1);
    ena_nxt  = (state_nxt == P1) || (state_nxt == P2);
    idx_nxt  = pulse_idx;
    if (state_nxt == P1) idx_nxt = 1'b0;
    if (state_nxt == P2) idx_nxt = 1'b1;
    err_nxt  = (state == IDLE) && start && !cfg_ok;
  end

  // Registered outputs and datapath; outputs are driven from the next-state decode so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ena          <= 1'b0;
      pulse_idx    <= 1'b0;
      pair_start   <= 1'b0;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      pair_count   <= 16'd0;
      stop_pending <= 1'b0;
      lfsr         <= LFSR_SEED;
      t            <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      prr_q        <= '0;
      mask_q       <= '0;
      interval_q   <= '0;
    end else begin
      ena        <= ena_nxt;
      pulse_idx  <= idx_nxt;
      pair_start <= new_pair;
      busy       <= (state_nxt != IDLE);
      cfg_err    <= err_nxt;

      if (new_pair)                t <= '0;
      else if (state_nxt != IDLE)  t <= t + ONE;

      if (accept) begin
        len_q        <= pulse_len;
        gap_q        <= pair_gap;
        prr_q        <= prr_base;
        mask_q       <= jitter_mask;
        pair_count   <= 16'd1;
        stop_pending <= stop;
      end else begin
        if (new_pair) pair_count <= pair_count + 16'd1;
        if (state_nxt == IDLE)                stop_pending <= 1'b0;
        else if (stop && (state != IDLE))     stop_pending <= 1'b1;
      end

      if (new_pair) begin
        interval_q <= interval_nxt;
        lfsr       <= lfsr_step;
      end
    end
  end

endmodule

// File: doc/dme_pulse_pair_sched.md
# dme_pulse_pair_sched

Sequencer for the DME interrogator transmit path. It produces the `ena` window that gates the pulse-shape address generator and waveform ROM, one window per pulse. It emits pulse pairs with a programmable pulse length, pair spacing and repetition interval. The repetition interval carries LFSR jitter, so the ranging receiver can reject replies meant for other interrogators. `pair_start` marks t0 for the range timer.

## Interface
Parameters:
- `CNT_W`, 32, width of timing inputs and internal cycle timer
- `LFSR_SEED`, 16'hACE1, reset value of the jitter LFSR; must be nonzero

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `start` in 1: single-cycle request to begin pair transmission
- `stop` in 1: single-cycle request to end transmission after the current pair interval
- `pulse_len` in CNT_W: cycles per pulse window (the pulse-shape ROM depth)
- `pair_gap` in CNT_W: cycles from pulse-1 start to pulse-2 start
- `prr_base` in CNT_W: nominal cycles from one pair start to the next
- `jitter_mask` in 16: AND mask applied to the LFSR to form the per-pair jitter
- `ena` out 1: pulse window; drives the address generator and ROM enable
- `pulse_idx` out 1: 0 during pulse 1, 1 during pulse 2; holds its last value otherwise
- `pair_start` out 1: one-cycle strobe in the first cycle of pulse 1
- `busy` out 1: high in every state except IDLE
- `cfg_err` out 1: one-cycle strobe when `start` is rejected for invalid configuration
- `pair_count` out 16: number of pairs started since the last accepted `start`

## Operation
- States: IDLE, P1, GAP, P2, WAIT.
- The cycle timer `t` is 0 in the first cycle of P1 and increments every cycle while `busy` is high.
- Configuration is latched from the inputs when `start` is accepted in IDLE. Input changes while `busy` is high have no effect.
- Valid configuration requires all of:
  - `pulse_len` ≥ 1
  - `pair_gap` > `pulse_len`
  - `prr_base` > `pair_gap` + `pulse_len`
- `start` with an invalid configuration: the block stays in IDLE and `cfg_err` = 1 for one cycle.
- IDLE → P1 on a valid `start`:
  - latch the configuration
  - clear `pair_count`
  - compute the interval
- Interval is `prr_base` + (`lfsr` & `jitter_mask`), added in CNT_W+1 bits and saturated to 2^CNT_W−1.
- Every transition into P1 does all of the following:
  - `pair_start` = 1 for that cycle
  - `pair_count` increments, wrapping at 16 bits
  - the LFSR advances one step
  - the interval for this pair is fixed
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It loads `LFSR_SEED` on reset and never reaches zero.
- P1: `ena`=1, `pulse_idx`=0, for t = 0 .. `pulse_len`−1. Then → GAP.
- GAP: `ena`=0 until t = `pair_gap`−1. Then → P2.
- P2: `ena`=1, `pulse_idx`=1, for t = `pair_gap` .. `pair_gap`+`pulse_len`−1. Then → WAIT.
- WAIT: `ena`=0 until t = interval−1. Then:
  - → IDLE if `stop_pending` is set
  - otherwise → P1 with t = 0
- `stop` in any non-IDLE state sets `stop_pending`. The current pair always completes, including its WAIT, so the repetition rate is never exceeded.
- `stop_pending` clears on entry to IDLE.
- `stop` in IDLE is ignored.
- `start` and `stop` in the same IDLE cycle: the start is accepted with `stop_pending` set, so exactly one pair is sent.
- `start` while `busy` is high is ignored.

## Timing
- All outputs are registered.
- Reset values: `ena`=0, `pulse_idx`=0, `pair_start`=0, `busy`=0, `cfg_err`=0, `pair_count`=0. State = IDLE, `stop_pending`=0, LFSR=`LFSR_SEED`.
- `start` sampled high at edge k: at k+1, `busy`=1, `ena`=1, `pair_start`=1 and `pair_count`=1.
- `cfg_err` asserts one cycle after the rejected `start`.
- `ena` is high for exactly `pulse_len` cycles per pulse. The rising edges of pulse 1 and pulse 2 are exactly `pair_gap` cycles apart.
- Consecutive `pair_start` strobes are exactly the interval apart; the interval is recomputed for each pair.
- After the last WAIT cycle, `busy`=0 on the next cycle.
- A new `start` is accepted in the same cycle `busy` first reads 0.
- `reset` asserted mid-pulse: `ena`=0 on the next cycle, no further pulses, and the LFSR reseeds.

## Test plan
- Single pair: `pulse_len`=4, `pair_gap`=10, `prr_base`=40, `jitter_mask`=0, `start` and `stop` together.
  - `ena` high for t=0..3 and 10..13.
  - `pair_start` at t=0 only.
  - `busy` falls after t=39.
  - `pair_count`=1.
- Free run: same configuration, `start` only, `stop` at t=95.
  - `pair_start` at t=0, 40 and 80.
  - `busy` falls after t=119.
  - `pair_count`=3.
- Jitter: `jitter_mask`=16'h000F, seed 16'hACE1.
  - Pair spacings equal 40 + (LFSR & 0xF) for each successive LFSR value, matched against a reference model.
  - No spacing below 40 or above 55.
- Invalid configuration: `pair_gap`=4 with `pulse_len`=4.
  - `cfg_err` pulses once.
  - `busy` and `ena` stay 0.
- Busy and mid-run changes: `start` pulses during P2, and `pulse_len` changes mid-run.
  - Both are ignored; the timing of the current and subsequent pairs is unchanged.
- Reset during pulse 2: `reset` at t=11.
  - At t=12, `ena`=0, `busy`=0 and `pair_count`=0.
  - A subsequent `start` gives jitter identical to a run from power-on.
